line_follow_ctrl: RTL

Clocked, parametrised successor to the rover's combinational motor-steering logic. It takes an N-sensor inductive tape array (active low), a proximity (cone) sensor and a red junction marker, and resolves them through a registered FSM. The FSM adds input debouncing, last-direction memory, cone avoidance with 180° turn, junction branch alternation, a turn timeout fault and PWM speed control. It sits between the sensor front-end pins and the H-bridge direction/enable pins.

---
 rtl/line_follow_pkg.sv | 29 ++
 rtl/sync_debounce.sv | 52 +++++
 rtl/line_follow_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/line_follow_pkg.sv
// Shared encodings for the line-following rover controller: H-bridge direction
// codes, FSM state encodings and tape classification results.
package line_follow_pkg;

    localparam logic [3:0] DIR_FWD   = 4'b0110;
    localparam logic [3:0] DIR_LEFT  = 4'b1010;
    localparam logic [3:0] DIR_RIGHT = 4'b0101;
    localparam logic [3:0] DIR_STOP  = 4'b0000;

    typedef enum logic [2:0] {
        ST_FOLLOW   = 3'd0,
        ST_AVOID    = 3'd1,
        ST_JUNCTION = 3'd2,
        ST_UTURN    = 3'd3,
        ST_FAULT    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CLS_TRACK    = 2'd0,
        CLS_LOST     = 2'd1,
        CLS_JUNC_ALL = 2'd2
    } cls_e;

    // Junction branch is kept as a single bit; 1 selects the left turn.
    function automatic logic [3:0] branch_dir(input logic left);
        return left ? DIR_LEFT : DIR_RIGHT;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a debouncer: the output takes a new value
// only after DEBOUNCE consecutive identical synchronised samples of it.
module sync_debounce #(
    parameter int            W        = 5,
    parameter int            DEBOUNCE = 4,
    parameter logic [W-1:0]  RST_VAL  = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [W-1:0]  s1_q, s2_q, cand_q, db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d = db_q;
        if (s2_q == db_q)
            cnt_d = '0;
        else if (s2_q != cand_q)
            cnt_d = CW'(1);
        else
            cnt_d = cnt_q + CW'(1);
        if (cnt_d == CW'(DEBOUNCE)) begin
            db_d  = s2_q;
            cnt_d = '0;
        end
    end

    // The synchroniser resets to the idle value too, so leaving reset never
    // looks like an input change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= RST_VAL;
            s2_q   <= RST_VAL;
            cand_q <= RST_VAL;
            db_q   <= RST_VAL;
            cnt_q  <= '0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            cand_q <= s2_q;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q_o = db_q;

endmodule

// File: rtl/line_follow_ctrl.sv
// Registered steering controller: debounced tape/cone/junction inputs drive an
// FSM producing H-bridge direction codes, gated by a free-running PWM.
module line_follow_ctrl
    import line_follow_pkg::*;
#(
    parameter int N_SENS   = 3,
    parameter int PWM_W    = 8,
    parameter int DEBOUNCE = 4,
    parameter int TURN_MAX = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SENS-1:0] induct,
    input  logic              proxim,
    input  logic              red,
    input  logic [PWM_W-1:0]  duty,
    output logic [3:0]        motor_in,
    output logic [1:0]        motor_en,
    output logic [2:0]        state_o,
    output logic              cone_seen,
    output logic              fault
);
    localparam int C   = N_SENS / 2;
    localparam int TW  = $clog2(TURN_MAX + 1);
    localparam int PCW = $clog2(N_SENS + 1);

    logic [N_SENS+1:0] db;
    logic [N_SENS-1:0] on;
    logic              prox_db, red_db, red_rise, centre_only;

    sync_debounce #(
        .W        (N_SENS + 2),
        .DEBOUNCE (DEBOUNCE),
        .RST_VAL  ({2'b00, {N_SENS{1'b1}}})
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({red, proxim, induct}),
        .q_o   (db)
    );

    assign on      = ~db[N_SENS-1:0];
    assign prox_db = db[N_SENS];
    assign red_db  = db[N_SENS+1];

    state_e           state_q, state_d;
    logic [3:0]       motor_q, motor_d, last_q, last_d;
    logic             branch_q, branch_d, cone_q, cone_d, fault_q, fault_d;
    logic             ured_q, ured_d, red_prev_q;
    logic [TW-1:0]    turn_q, turn_d;
    logic [PWM_W-1:0] pwm_q;

    cls_e           cls;
    logic [3:0]     track_dir;
    logic [PCW-1:0] cnt_l, cnt_r;

    assign red_rise    = red_db & ~red_prev_q;
    assign centre_only = (on == (N_SENS'(1) << C));

    always_comb begin
        cnt_l = '0;
        cnt_r = '0;
        for (int i = C + 1; i < N_SENS; i++) cnt_l = cnt_l + PCW'(on[i]);
        for (int i = 0; i < C; i++)          cnt_r = cnt_r + PCW'(on[i]);
        if (on == '0)      cls = CLS_LOST;
        else if (&on)      cls = CLS_JUNC_ALL;
        else               cls = CLS_TRACK;
        if (cnt_l > cnt_r)      track_dir = DIR_LEFT;
        else if (cnt_r > cnt_l) track_dir = DIR_RIGHT;
        else                    track_dir = DIR_FWD;
    end

    // motor_d is the code for the cycle after the transition, so motor_in
    // lags the debounced inputs by exactly one register.
    always_comb begin
        state_d  = state_q;
        motor_d  = motor_q;
        last_d   = last_q;
        branch_d = branch_q;
        cone_d   = cone_q;
        fault_d  = fault_q;
        ured_d   = ured_q;
        turn_d   = '0;
        case (state_q)
            ST_FOLLOW: begin
                if (prox_db) begin
                    state_d = ST_AVOID;
                    motor_d = DIR_LEFT;
                    cone_d  = 1'b1;
                end else if (red_rise && cone_q) begin
                    state_d = ST_UTURN;
                    ured_d  = 1'b1;
                    motor_d = branch_dir(branch_q);
                end else if (red_rise) begin
                    state_d  = ST_JUNCTION;
                    branch_d = ~branch_q;
                    motor_d  = branch_dir(~branch_q);
                end else if (cls == CLS_TRACK) begin
                    motor_d = track_dir;
                    last_d  = track_dir;
                end else begin
                    motor_d = last_q;
                end
            end
            ST_AVOID: begin
                motor_d = DIR_LEFT;
                cone_d  = 1'b1;
                if (!prox_db) begin
                    state_d = ST_UTURN;
                    ured_d  = 1'b0;
                end
            end
            ST_JUNCTION: begin
                motor_d = branch_dir(branch_q);
                if (!red_db) begin
                    state_d = ST_FOLLOW;
                    cone_d  = 1'b0;
                    last_d  = branch_dir(branch_q);
                end
            end
            ST_UTURN: begin
                motor_d = ured_q ? branch_dir(branch_q) : DIR_LEFT;
                turn_d  = turn_q + TW'(1);
                if (centre_only) begin
                    state_d = ST_FOLLOW;
                    turn_d  = '0;
                end else if (turn_d == TW'(TURN_MAX)) begin
                    state_d = ST_FAULT;
                    motor_d = DIR_STOP;
                    fault_d = 1'b1;
                end
            end
            ST_FAULT: begin
                motor_d = DIR_STOP;
                fault_d = 1'b1;
            end
            default: begin
                state_d = ST_FAULT;
                motor_d = DIR_STOP;
                fault_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FOLLOW;
            motor_q    <= DIR_STOP;
            last_q     <= DIR_FWD;
            branch_q   <= 1'b0;
            cone_q     <= 1'b0;
            fault_q    <= 1'b0;
            ured_q     <= 1'b0;
            red_prev_q <= 1'b0;
            turn_q     <= '0;
            pwm_q      <= '0;
        end else begin
            state_q    <= state_d;
            motor_q    <= motor_d;
            last_q     <= last_d;
            branch_q   <= branch_d;
            cone_q     <= cone_d;
            fault_q    <= fault_d;
            ured_q     <= ured_d;
            red_prev_q <= red_db;
            turn_q     <= turn_d;
            pwm_q      <= pwm_q + PWM_W'(1);
        end
    end

    assign motor_in  = motor_q;
    assign motor_en  = (motor_q != DIR_STOP && pwm_q < duty) ? 2'b11 : 2'b00;
    assign state_o   = state_q;
    assign cone_seen = cone_q;
    assign fault     = fault_q;

endmodule
